// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only data memory: byte/half/word access with read-merge-write sub-word stores.
// Define MAU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of forcing natural alignment.
module mem_access_unit #(
   parameter int DM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              addr_err,
   output logic [DM_AW-1:0]  dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   input  logic [31:0]       dm_dout
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]       state_q, state_d;
   logic             we_q, we_d;
   logic [1:0]       size_q, size_d;
   logic             unsigned_q, unsigned_d;
   logic [DM_AW+1:0] addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      word_q, word_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             illegal;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic [31:0]      load_val;
   logic [31:0]      merged;
   logic             unused_addr_hi;

   // Byte addresses wrap inside the memory window; upper bits carry no meaning here.
   assign unused_addr_hi = ^req_addr[31:DM_AW+2];

   always_comb begin
      illegal = (size_q == 2'b11);
`ifdef MAU_ALIGN_CHECK_EN
      if (size_q == SZ_HALF && addr_q[0])
         illegal = 1'b1;
      if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
         illegal = 1'b1;
`endif
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_lane = dm_dout[7:0];
         2'd1:    byte_lane = dm_dout[15:8];
         2'd2:    byte_lane = dm_dout[23:16];
         default: byte_lane = dm_dout[31:24];
      endcase
      half_lane = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

      case (size_q)
         SZ_BYTE: load_val = {{24{byte_lane[7] & ~unsigned_q}}, byte_lane};
         SZ_HALF: load_val = {{16{half_lane[15] & ~unsigned_q}}, half_lane};
         default: load_val = dm_dout;
      endcase
   end

   // Sub-word store: splice the new lane into the word captured during ACCESS.
   always_comb begin
      merged = word_q;
      if (size_q == SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      err_d      = err_q;
      rdata_d    = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d       = req_we;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               addr_d     = req_addr[DM_AW+1:0];
               wdata_d    = req_wdata;
               err_d      = 1'b0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            err_d = illegal;
            if (illegal) begin
               state_d = S_DONE;
            end else if (!we_q) begin
               rdata_d = load_val;
               state_d = S_DONE;
            end else if (size_q == SZ_WORD) begin
               state_d = S_DONE;
            end else begin
               word_d  = dm_dout;
               state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_q     <= word_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign addr_err = (state_q == S_DONE) && err_q;
   assign rdata    = rdata_q;
   assign dm_addr  = addr_q[DM_AW+1:2];
   // The write strobe is gated by reset so a reset landing mid-store never corrupts memory.
   assign dm_we    = !rst && ((state_q == S_WRITE) ||
                              (state_q == S_ACCESS && we_q && !illegal && size_q == SZ_WORD));
   assign dm_din   = (state_q == S_WRITE) ? merged : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: cycle-level behavioural model plus directed accesses with literal expectations.
// Builds with or without MAU_ALIGN_CHECK_EN; expectations follow the same macro.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        busy, done, addr_err, dm_we;
   logic [31:0] rdata, dm_din, dm_dout;
   logic [9:0]  dm_addr;

   int n_tests = 0;
   int n_fail  = 0;
   int dm_we_count = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DM_AW(10)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
      .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
   );

   // Data memory the unit talks to
   logic [31:0] tb_mem [0:1023];
   assign dm_dout = tb_mem[dm_addr];
   always @(posedge clk) begin
      if (dm_we) begin
         tb_mem[dm_addr] <= dm_din;
         dm_we_count <= dm_we_count + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'b11) return 1'b1;
`ifdef MAU_ALIGN_CHECK_EN
      if (size == 2'b01 && addr[0]) return 1'b1;
      if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] size,
                                              input logic uns, input logic [31:0] addr);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (w >> (8 * addr[1:0])) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> (16 * addr[1])) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] store_word(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      if (size == 2'b00) r[8 * addr[1:0] +: 8] = wd[7:0];
      else if (size == 2'b01) r[16 * addr[1] +: 16] = wd[15:0];
      else r = wd;
      return r;
   endfunction

   logic [31:0] ref_mem [0:1023];
   logic        m_active = 1'b0;
   int          m_cyc = 0;
   int          m_lat = 2;
   logic        m_we = 1'b0, m_uns = 1'b0, m_err = 1'b0;
   logic [1:0]  m_size = 2'b00;
   logic [31:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;

   // Model timeline: cycle 1 follows the accepting edge; done in cycle m_lat; the write in cycle m_lat-1.
   always @(posedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         exp_rdata = '0;
         m_addr = '0;
         m_wdata = '0;
      end else if (m_active) begin
         if (m_cyc == m_lat) begin
            m_active = 1'b0;
         end else begin
            if (m_cyc == m_lat - 1 && !m_err) begin
               if (m_we)
                  ref_mem[m_addr[11:2]] = store_word(ref_mem[m_addr[11:2]], m_size, m_addr, m_wdata);
               else
                  exp_rdata = load_value(ref_mem[m_addr[11:2]], m_size, m_uns, m_addr);
            end
            m_cyc++;
         end
      end else if (req) begin
         m_we = req_we; m_size = req_size; m_uns = req_unsigned;
         m_addr = req_addr; m_wdata = req_wdata;
         m_err = is_illegal(req_size, req_addr);
         m_lat = (m_we && !m_err && m_size != 2'b10) ? 3 : 2;
         m_cyc = 1;
         m_active = 1'b1;
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      logic e_done, e_wstate, e_we;
      e_done   = m_active && (m_cyc == m_lat);
      e_wstate = m_active && !m_err && m_we && (m_cyc == m_lat - 1);
      e_we     = e_wstate && !rst;
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("addr_err", {31'd0, addr_err}, {31'd0, e_done && m_err});
      check("dm_we", {31'd0, dm_we}, {31'd0, e_we});
      check("rdata", rdata, exp_rdata);
      if (m_active) begin
         check("dm_addr", {22'd0, dm_addr}, {22'd0, m_addr[11:2]});
         check("dm_din", dm_din,
               e_wstate ? store_word(ref_mem[m_addr[11:2]], m_size, m_addr, m_wdata) : m_wdata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic access(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         input int exp_lat, input int exp_writes, output logic err_o);
      int n;
      int w0;
      w0 = dm_we_count;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req = 1'b1;
      tick();
      n = 1;
      if (n > hold) req = 1'b0;
      while (!done && n < 10) begin
         tick();
         n++;
         if (n > hold) req = 1'b0;
      end
      req = 1'b0;
      err_o = addr_err;
      check({name, "_latency"}, n, exp_lat);
      tick();
      check({name, "_writes"}, dm_we_count - w0, exp_writes);
      $display("[TB] %s we=%0d size=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
               name, we, size, addr, wd, n, err_o, rdata);
   endtask

   logic err;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         tb_mem[i] = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_dm_din", dm_din, 32'h0);
      check("reset_dm_addr", {22'd0, dm_addr}, 32'h0);

      access("SW", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 0, 2, 1, err);
      check("SW_err", {31'd0, err}, 32'd0);
      check("SW_mem", tb_mem[4], 32'h8899AABB);
      access("LB", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 2, 0, err);
      check("LB_rdata", rdata, 32'hFFFFFFAA);
      access("LBU", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 2, 0, err);
      check("LBU_rdata", rdata, 32'h00000088);
      access("LH", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 2, 0, err);
      check("LH_rdata", rdata, 32'hFFFF8899);
      access("LHU", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 2, 0, err);
      check("LHU_rdata", rdata, 32'h00008899);
      access("SH", 1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234, 0, 3, 1, err);
      check("SH_mem", tb_mem[4], 32'h1234AABB);
      access("SB", 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, 0, 3, 1, err);
      check("SB_mem", tb_mem[4], 32'h1234AA55);

`ifdef MAU_ALIGN_CHECK_EN
      access("LH_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 2, 0, err);
      check("LH_mis_err", {31'd0, err}, 32'd1);
      check("LH_mis_rdata", rdata, 32'h00008899);
      access("SW_mis", 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 0, 2, 0, err);
      check("SW_mis_err", {31'd0, err}, 32'd1);
      check("SW_mis_mem", tb_mem[8], 32'h0);
`else
      access("LH_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 2, 0, err);
      check("LH_mis_err", {31'd0, err}, 32'd0);
      check("LH_mis_rdata", rdata, 32'hFFFFAA55);
      access("SW_mis", 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 0, 2, 1, err);
      check("SW_mis_err", {31'd0, err}, 32'd0);
      check("SW_mis_mem", tb_mem[8], 32'hCAFEF00D);
`endif

      // req held for three cycles across an SB: still a single access
      access("SB_hold", 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000066, 2, 3, 1, err);
      check("SB_hold_mem", tb_mem[4], 32'h6634AA55);
      access("LW_wrap", 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 0, 2, 0, err);
      check("LW_wrap_rdata", rdata, 32'h6634AA55);

      // reset asserted during the WRITE cycle of an SB
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h77;
      req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rstw_dm_we", {31'd0, dm_we}, 32'd0);
      check("rstw_busy", {31'd0, busy}, 32'd1);
      tick();
      rst = 1'b0;
      check("rstw_after_busy", {31'd0, busy}, 32'd0);
      check("rstw_after_done", {31'd0, done}, 32'd0);
      check("rstw_after_rdata", rdata, 32'h0);
      check("rstw_after_dm_din", dm_din, 32'h0);
      check("rstw_mem", tb_mem[4], 32'h6634AA55);
      $display("[TB] reset during SB write -> mem[4]=0x%08h busy=%0d", tb_mem[4], busy);
      tick();

      access("LBU2", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 2, 0, err);
      check("LBU2_rdata", rdata, 32'h00000066);
      access("ILL", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 2, 0, err);
      check("ILL_err", {31'd0, err}, 32'd1);
      check("ILL_rdata", rdata, 32'h00000066);
      check("ILL_err_clear", {31'd0, addr_err}, 32'd0);
      access("ILL_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 0, 2, 0, err);
      check("ILL_st_err", {31'd0, err}, 32'd1);
      check("ILL_st_mem", tb_mem[4], 32'h6634AA55);

      for (int i = 0; i < 16; i++)
         check("mem_vs_model", tb_mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
